// File: rtl/constants.sv
// Shared type definitions for the FPU operation arbiter and the datapath it feeds.
package constants;

    typedef logic [15:0] fp16_t;
    typedef logic [2:0]  opStatusFlag_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } fpuOp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arbState_t;

    // Width of a requester index; never below one bit so NREQ == 1 still elaborates.
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Round-robin grant: the first asserted request found scanning circularly from the pointer.
module fpu_rr_arbiter
    import constants::*;
#(
    parameter  int NREQ = 2,
    localparam int PW   = ptrWidth(NREQ)
) (
    input  logic [NREQ-1:0] request,
    input  logic [PW-1:0]   pointer,
    output logic [NREQ-1:0] grant
);

    always_comb begin
        logic [PW-1:0] idx;
        logic          found;
        grant = '0;
        idx   = pointer;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && request[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
            idx = (idx == PW'(NREQ - 1)) ? '0 : idx + PW'(1);
        end
    end

endmodule

// File: rtl/fpu_op_arbiter.sv
// Shares one FPU datapath among NREQ requesters: one op in flight at a time,
// round-robin grant, per-requester response routing and sticky status flags.
module fpu_op_arbiter
    import constants::*;
#(
    parameter type FP_T = fp16_t,
    parameter int  NREQ = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NREQ-1:0]            reqValid,
    output logic [NREQ-1:0]            reqReady,
    input  fpuOp_t [NREQ-1:0]          reqOp,
    input  FP_T [NREQ-1:0]             reqA,
    input  FP_T [NREQ-1:0]             reqB,
    output logic [NREQ-1:0]            rspValid,
    input  logic [NREQ-1:0]            rspReady,
    output FP_T                        rspResult,
    output opStatusFlag_t              rspFlags,
    output logic                       fpuStart,
    output fpuOp_t                     fpuOp,
    output FP_T                        fpuA,
    output FP_T                        fpuB,
    input  logic                       fpuDone,
    input  FP_T                        fpuResult,
    input  opStatusFlag_t              fpuFlags,
    output opStatusFlag_t [NREQ-1:0]   accFlags,
    output logic                       busy,
    input  logic [NREQ-1:0]            flagClear
);

    localparam int PW = ptrWidth(NREQ);

    arbState_t                  stateReg, stateNext;
    logic [PW-1:0]              ptrReg, ownerReg, grantIdx;
    logic [NREQ-1:0]            grant;
    fpuOp_t                     opReg;
    FP_T                        aReg, bReg, resultReg;
    opStatusFlag_t              flagsReg;
    opStatusFlag_t [NREQ-1:0]   accFlagsReg, accFlagsNext;
    logic                       grantTake, capture, respActive;

    fpu_rr_arbiter #(.NREQ(NREQ)) uRrArbiter (
        .request (reqValid),
        .pointer (ptrReg),
        .grant   (grant)
    );

    always_comb begin
        grantIdx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grantIdx = PW'(i);
        end
    end

    always_comb begin
        stateNext  = stateReg;
        reqReady   = '0;
        fpuStart   = 1'b0;
        grantTake  = 1'b0;
        capture    = 1'b0;
        respActive = 1'b0;
        case (stateReg)
            IDLE: begin
                if (|reqValid) begin
                    reqReady  = grant;
                    grantTake = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                fpuStart = 1'b1;
                // A zero-latency datapath may complete in the issue cycle itself.
                if (fpuDone) begin
                    capture   = 1'b1;
                    stateNext = RESP;
                end else begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (fpuDone) begin
                    capture   = 1'b1;
                    stateNext = RESP;
                end
            end
            RESP: begin
                respActive = 1'b1;
                if (rspReady[ownerReg]) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (reset) begin
            reqReady   = '0;
            fpuStart   = 1'b0;
            grantTake  = 1'b0;
            capture    = 1'b0;
            respActive = 1'b0;
        end
    end

    // Clear first, then OR-in, so flags arriving in the clear cycle survive.
    always_comb begin
        accFlagsNext = accFlagsReg;
        for (int i = 0; i < NREQ; i++) begin
            if (flagClear[i]) accFlagsNext[i] = '0;
            if (capture && (ownerReg == PW'(i))) accFlagsNext[i] = accFlagsNext[i] | fpuFlags;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateReg    <= IDLE;
            ptrReg      <= '0;
            ownerReg    <= '0;
            opReg       <= OP_ADD;
            aReg        <= '0;
            bReg        <= '0;
            resultReg   <= '0;
            flagsReg    <= '0;
            accFlagsReg <= '0;
        end else begin
            stateReg    <= stateNext;
            accFlagsReg <= accFlagsNext;
            if (grantTake) begin
                ownerReg <= grantIdx;
                ptrReg   <= (grantIdx == PW'(NREQ - 1)) ? '0 : grantIdx + PW'(1);
                opReg    <= reqOp[grantIdx];
                aReg     <= reqA[grantIdx];
                bReg     <= reqB[grantIdx];
            end
            if (capture) begin
                resultReg <= fpuResult;
                flagsReg  <= fpuFlags;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : genRsp
            assign rspValid[gi] = respActive && (ownerReg == PW'(gi));
        end
    endgenerate

    assign fpuOp     = reset ? OP_ADD : opReg;
    assign fpuA      = reset ? '0 : aReg;
    assign fpuB      = reset ? '0 : bReg;
    assign rspResult = resultReg;
    assign rspFlags  = flagsReg;
    assign accFlags  = accFlagsReg;
    assign busy      = !reset && (stateReg != IDLE);

endmodule
